// File: rtl/maxpool_nxn_if.sv
// rtl/maxpool_nxn_if.sv - pixel stream in / pooled pixel out bundle for maxpool_nxn
interface maxpool_nxn_if #(
  parameter int BW = 16,
  parameter int CH = 1
) ();
  logic               i_valid;
  logic [CH*BW-1:0]   i_data;
  logic               o_valid;
  logic [CH*BW-1:0]   o_data;
  logic               o_end;

  modport master (
    output i_valid, i_data,
    input  o_valid, o_data, o_end
  );

  modport slave (
    input  i_valid, i_data,
    output o_valid, o_data, o_end
  );
endinterface

// File: rtl/maxpool_nxn.sv
// rtl/maxpool_nxn.sv - streaming non-overlapping P_SIZE x P_SIZE max/average pooling
// Horizontal reduction in h_acc, vertical reduction through a one-row line buffer.
module maxpool_nxn #(
  parameter int BW      = 16,
  parameter int CH      = 1,
  parameter int P_SIZE  = 2,
  parameter int IF_SIZE = 8,
  parameter int MODE    = 0
) (
  input  logic         clk,
  input  logic         global_rst_n,
  input  logic         rst,
  maxpool_nxn_if.slave bus
);
  localparam int LOG2P = (P_SIZE == 4) ? 2 : 1;
  localparam int SH    = (MODE == 1) ? 2 * LOG2P : 0;
  localparam int AW    = BW + SH;
  localparam int NW    = IF_SIZE / P_SIZE;
  localparam int CW    = (IF_SIZE > 1) ? $clog2(IF_SIZE) : 1;
  localparam int IW    = (NW > 1) ? $clog2(NW) : 1;

  if ((P_SIZE != 2 && P_SIZE != 4) || (IF_SIZE % P_SIZE != 0) || (MODE != 0 && MODE != 1))
  begin : g_bad_params
    $error("maxpool_nxn: P_SIZE must be 2 or 4, IF_SIZE a multiple of P_SIZE, MODE 0 or 1");
  end

  typedef logic signed [AW-1:0] acc_t;

  function automatic acc_t op_f(input acc_t a, input acc_t b);
    acc_t r;
    if (MODE == 0) r = (a > b) ? a : b;
    else           r = a + b;
    return r;
  endfunction

  logic [CW-1:0]    col;
  logic [CW-1:0]    row;
  logic [LOG2P-1:0] ph;
  logic [LOG2P-1:0] pv;
  logic [IW-1:0]    idx;
  logic             win_start;
  logic             win_end;
  logic             row_first;
  logic             row_last_win;
  logic             frame_end;

  acc_t             samp  [CH];
  acc_t             h_acc [CH];
  acc_t             h_new [CH];
  acc_t             v_new [CH];
  acc_t             lbuf  [CH][NW];
  logic [CH*BW-1:0] fin_all;

  logic             o_valid_q;
  logic             o_end_q;
  logic [CH*BW-1:0] o_data_q;

  // P_SIZE is a power of two, so window phase and line-buffer index are bit slices
  assign ph           = col[LOG2P-1:0];
  assign pv           = row[LOG2P-1:0];
  assign idx          = IW'(col >> LOG2P);
  assign win_start    = (ph == '0);
  assign win_end      = (ph == '1);
  assign row_first    = (pv == '0);
  assign row_last_win = (pv == '1);
  assign frame_end    = (col == CW'(IF_SIZE - 1)) && (row == CW'(IF_SIZE - 1));

  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic signed [BW-1:0] x;
    assign x        = bus.i_data[c*BW +: BW];
    assign samp[c]  = AW'(x);
    assign h_new[c] = op_f(h_acc[c], samp[c]);
    assign v_new[c] = op_f(lbuf[c][idx], h_new[c]);
    // Average divides by P*P with an arithmetic shift (floor toward -inf)
    assign fin_all[c*BW +: BW] = v_new[c][SH +: BW];
  end

  always_ff @(posedge clk or negedge global_rst_n) begin
    if (!global_rst_n) begin
      col       <= '0;
      row       <= '0;
      o_valid_q <= 1'b0;
      o_end_q   <= 1'b0;
      o_data_q  <= '0;
      for (int c = 0; c < CH; c++) h_acc[c] <= '0;
    end else if (rst) begin
      col       <= '0;
      row       <= '0;
      o_valid_q <= 1'b0;
      o_end_q   <= 1'b0;
      o_data_q  <= '0;
      for (int c = 0; c < CH; c++) h_acc[c] <= '0;
    end else begin
      o_valid_q <= 1'b0;
      o_end_q   <= 1'b0;
      if (bus.i_valid) begin
        if (col == CW'(IF_SIZE - 1)) begin
          col <= '0;
          row <= (row == CW'(IF_SIZE - 1)) ? '0 : row + CW'(1);
        end else begin
          col <= col + CW'(1);
        end
        for (int c = 0; c < CH; c++) h_acc[c] <= win_start ? samp[c] : h_new[c];
        if (win_end && row_last_win) begin
          o_valid_q <= 1'b1;
          o_end_q   <= frame_end;
          o_data_q  <= fin_all;
        end
      end
    end
  end

  // No reset needed: the first row of every window band overwrites its entry
  always_ff @(posedge clk) begin
    if (!rst && bus.i_valid && win_end && !row_last_win) begin
      for (int c = 0; c < CH; c++) lbuf[c][idx] <= row_first ? h_new[c] : v_new[c];
    end
  end

  assign bus.o_valid = o_valid_q;
  assign bus.o_end   = o_end_q;
  assign bus.o_data  = o_data_q;
endmodule

// File: tb/tb_maxpool_nxn.sv
// tb/tb_maxpool_nxn.sv - directed checks of maxpool_nxn in max, average and multi-channel configurations
module tb_maxpool_nxn;
  logic clk          = 1'b0;
  logic global_rst_n = 1'b0;
  logic rst          = 1'b0;
  int   errors       = 0;
  int   checks       = 0;

  always #5 clk = ~clk;

  maxpool_nxn_if #(.BW(16), .CH(1)) mx ();
  maxpool_nxn_if #(.BW(16), .CH(1)) av ();
  maxpool_nxn_if #(.BW(16), .CH(2)) mc ();

  maxpool_nxn #(.BW(16), .CH(1), .P_SIZE(2), .IF_SIZE(4), .MODE(0)) u_max (
    .clk(clk), .global_rst_n(global_rst_n), .rst(rst), .bus(mx));
  maxpool_nxn #(.BW(16), .CH(1), .P_SIZE(2), .IF_SIZE(4), .MODE(1)) u_avg (
    .clk(clk), .global_rst_n(global_rst_n), .rst(rst), .bus(av));
  maxpool_nxn #(.BW(16), .CH(2), .P_SIZE(4), .IF_SIZE(8), .MODE(0)) u_mc (
    .clk(clk), .global_rst_n(global_rst_n), .rst(rst), .bus(mc));

  logic [15:0] q_mx [$];
  logic [15:0] q_av [$];
  logic        e_mx [$];
  logic [31:0] q_mc [$];
  int          mc_ends;

  task automatic clear_q();
    q_mx.delete();
    q_av.delete();
    e_mx.delete();
    q_mc.delete();
    mc_ends = 0;
  endtask

  task automatic step_pair(input logic [15:0] d, input logic v);
    mx.i_valid = v;
    mx.i_data  = d;
    av.i_valid = v;
    av.i_data  = d;
    @(negedge clk);
    if (mx.o_valid === 1'b1) begin
      q_mx.push_back(mx.o_data);
      e_mx.push_back(mx.o_end);
    end
    if (av.o_valid === 1'b1) q_av.push_back(av.o_data);
  endtask

  task automatic step_mc(input logic [31:0] d, input logic v);
    mc.i_valid = v;
    mc.i_data  = d;
    @(negedge clk);
    if (mc.o_valid === 1'b1) begin
      q_mc.push_back(mc.o_data);
      if (mc.o_end === 1'b1) mc_ends++;
    end
  endtask

  task automatic test_reset();
    mx.i_valid = 1'b0; mx.i_data = '0;
    av.i_valid = 1'b0; av.i_data = '0;
    mc.i_valid = 1'b0; mc.i_data = '0;
    repeat (3) @(negedge clk);
    checks++; if (mx.o_valid !== 1'b0) begin errors++; $display("FAIL reset_mx_valid got %b want 0", mx.o_valid); end
    checks++; if (mx.o_end !== 1'b0) begin errors++; $display("FAIL reset_mx_end got %b want 0", mx.o_end); end
    checks++; if (mx.o_data !== 16'd0) begin errors++; $display("FAIL reset_mx_data got %h want 0", mx.o_data); end
    checks++; if (av.o_data !== 16'd0) begin errors++; $display("FAIL reset_av_data got %h want 0", av.o_data); end
    checks++; if (mc.o_valid !== 1'b0) begin errors++; $display("FAIL reset_mc_valid got %b want 0", mc.o_valid); end
    checks++; if (mc.o_data !== 32'd0) begin errors++; $display("FAIL reset_mc_data got %h want 0", mc.o_data); end
    global_rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_baseline();
    logic [15:0] exp_max [4];
    logic [15:0] exp_avg [4];
    logic        exp_v;
    exp_max = '{16'd5, 16'd7, 16'd13, 16'd15};
    exp_avg = '{16'd2, 16'd4, 16'd10, 16'd12};
    clear_q();
    for (int k = 0; k < 16; k++) begin
      step_pair(16'(k), 1'b1);
      exp_v = (k == 5) || (k == 7) || (k == 13) || (k == 15);
      checks++;
      if (mx.o_valid !== exp_v) begin errors++; $display("FAIL base_valid[%0d] got %b want %b", k, mx.o_valid, exp_v); end
      checks++;
      if (mx.o_end !== (k == 15)) begin errors++; $display("FAIL base_end[%0d] got %b want %b", k, mx.o_end, (k == 15)); end
    end
    step_pair(16'd0, 1'b0);
    checks++; if (mx.o_valid !== 1'b0) begin errors++; $display("FAIL base_idle_valid got %b want 0", mx.o_valid); end
    checks++; if (mx.o_data !== 16'd15) begin errors++; $display("FAIL base_hold got %0d want 15", mx.o_data); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (q_mx[i] !== exp_max[i] || q_mx.size() != 4) begin
        errors++; $display("FAIL base_max[%0d] got %0d (n=%0d) want %0d", i, q_mx[i], q_mx.size(), exp_max[i]);
      end
      checks++;
      if (q_av[i] !== exp_avg[i] || q_av.size() != 4) begin
        errors++; $display("FAIL base_avg[%0d] got %0d (n=%0d) want %0d", i, q_av[i], q_av.size(), exp_avg[i]);
      end
    end
  endtask

  task automatic test_negative();
    logic [15:0] px [16];
    logic [15:0] exp_max [4];
    logic [15:0] exp_avg [4];
    for (int f = 0; f < 2; f++) begin
      if (f == 0) begin
        for (int k = 0; k < 16; k++) px[k] = 16'd0;
        px[0] = 16'(-1); px[1] = 16'(-2); px[4] = 16'(-3); px[5] = 16'(-4);
        exp_max = '{16'(-1), 16'd0, 16'd0, 16'd0};
        exp_avg = '{16'(-3), 16'd0, 16'd0, 16'd0};
      end else begin
        for (int k = 0; k < 16; k++) px[k] = 16'h8000;
        px[10] = 16'(-5);
        exp_max = '{16'h8000, 16'h8000, 16'h8000, 16'(-5)};
        exp_avg = '{16'h8000, 16'h8000, 16'h8000, 16'(-24578)};
      end
      clear_q();
      for (int k = 0; k < 16; k++) step_pair(px[k], 1'b1);
      step_pair(16'd0, 1'b0);
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (q_mx[i] !== exp_max[i] || q_mx.size() != 4) begin
          errors++; $display("FAIL neg%0d_max[%0d] got %0d (n=%0d) want %0d", f, i, $signed(q_mx[i]), q_mx.size(), $signed(exp_max[i]));
        end
        checks++;
        if (q_av[i] !== exp_avg[i] || q_av.size() != 4) begin
          errors++; $display("FAIL neg%0d_avg[%0d] got %0d (n=%0d) want %0d", f, i, $signed(q_av[i]), q_av.size(), $signed(exp_avg[i]));
        end
      end
    end
  endtask

  task automatic test_multichannel_gaps();
    logic [31:0] exp_mc [4];
    exp_mc = '{{16'd0, 16'd27}, {16'(-4), 16'd31}, {16'(-32), 16'd59}, {16'(-36), 16'd63}};
    for (int run = 0; run < 2; run++) begin
      clear_q();
      for (int k = 0; k < 64; k++) begin
        if (run == 1) begin
          int gap = $urandom_range(0, 3);
          for (int g = 0; g < gap; g++) step_mc(32'hdead_beef, 1'b0);
        end
        step_mc({16'(-k), 16'(k)}, 1'b1);
      end
      repeat (3) step_mc(32'd0, 1'b0);
      checks++;
      if (q_mc.size() != 4) begin errors++; $display("FAIL mc%0d_count got %0d want 4", run, q_mc.size()); end
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (q_mc[i] !== exp_mc[i]) begin errors++; $display("FAIL mc%0d_data[%0d] got %h want %h", run, i, q_mc[i], exp_mc[i]); end
      end
      checks++;
      if (mc_ends != 1) begin errors++; $display("FAIL mc%0d_end_count got %0d want 1", run, mc_ends); end
      checks++;
      if (mc.o_data !== exp_mc[3] || mc.o_valid !== 1'b0) begin
        errors++; $display("FAIL mc%0d_hold got %h/%b want %h/0", run, mc.o_data, mc.o_valid, exp_mc[3]);
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic [15:0] exp_max [4];
    logic [15:0] exp_avg [4];
    exp_max = '{16'd5, 16'd7, 16'd13, 16'd15};
    exp_avg = '{16'd2, 16'd4, 16'd10, 16'd12};
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 0) begin
        for (int k = 0; k < 6; k++) step_pair(16'(100 + k), 1'b1);
        rst = 1'b1;
        step_pair(16'd999, 1'b1);
        rst = 1'b0;
      end else begin
        for (int k = 0; k < 6; k++) step_pair(16'(k), 1'b1);
        mx.i_valid = 1'b0;
        av.i_valid = 1'b0;
        #2 global_rst_n = 1'b0;
        #1;
        checks++;
        if (mx.o_data !== 16'd0 || mx.o_valid !== 1'b0) begin
          errors++; $display("FAIL async_mx got %0d/%b want 0/0", mx.o_data, mx.o_valid);
        end
        checks++;
        if (av.o_data !== 16'd0) begin errors++; $display("FAIL async_av got %0d want 0", av.o_data); end
        @(negedge clk);
        global_rst_n = 1'b1;
      end
      clear_q();
      for (int k = 0; k < 16; k++) step_pair(16'(k), 1'b1);
      step_pair(16'd0, 1'b0);
      checks++;
      if (q_mx.size() != 4 || q_av.size() != 4) begin
        errors++; $display("FAIL rst%0d_count got %0d/%0d want 4/4", pass, q_mx.size(), q_av.size());
      end
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (q_mx[i] !== exp_max[i]) begin errors++; $display("FAIL rst%0d_max[%0d] got %0d want %0d", pass, i, q_mx[i], exp_max[i]); end
        checks++;
        if (q_av[i] !== exp_avg[i]) begin errors++; $display("FAIL rst%0d_avg[%0d] got %0d want %0d", pass, i, q_av[i], exp_avg[i]); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_max [8];
    logic [15:0] exp_avg [8];
    int          ends;
    exp_max = '{16'd5, 16'd7, 16'd13, 16'd15, 16'd15, 16'd13, 16'd7, 16'd5};
    exp_avg = '{16'd2, 16'd4, 16'd10, 16'd12, 16'd12, 16'd10, 16'd4, 16'd2};
    clear_q();
    for (int k = 0; k < 16; k++) step_pair(16'(k), 1'b1);
    for (int k = 0; k < 16; k++) step_pair(16'(15 - k), 1'b1);
    step_pair(16'd0, 1'b0);
    checks++;
    if (q_mx.size() != 8 || q_av.size() != 8) begin
      errors++; $display("FAIL b2b_count got %0d/%0d want 8/8", q_mx.size(), q_av.size());
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (q_mx[i] !== exp_max[i]) begin errors++; $display("FAIL b2b_max[%0d] got %0d want %0d", i, q_mx[i], exp_max[i]); end
      checks++;
      if (q_av[i] !== exp_avg[i]) begin errors++; $display("FAIL b2b_avg[%0d] got %0d want %0d", i, q_av[i], exp_avg[i]); end
    end
    ends = 0;
    foreach (e_mx[i]) if (e_mx[i] === 1'b1) ends++;
    checks++;
    if (ends != 2 || e_mx[3] !== 1'b1 || e_mx[7] !== 1'b1) begin
      errors++; $display("FAIL b2b_end got %0d pulses (e3=%b e7=%b) want 2 at outputs 3 and 7", ends, e_mx[3], e_mx[7]);
    end
  endtask

  initial begin
    test_reset();
    test_baseline();
    test_negative();
    test_multichannel_gaps();
    test_reset_midframe();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/maxpool_nxn.md
# maxpool_nxn

Parametrised streaming pooling stage for the CNN datapath, replacing the fixed 2×2 single-channel max-pool. It consumes a raster-ordered, square feature map of CH packed signed channels, one pixel per `i_valid` beat. It emits one pooled pixel per non-overlapping P_SIZE×P_SIZE window, in either max or average mode. It sits between a convolution/ReLU stage and the next layer's input buffer, with no backpressure, in the same single-clock domain.

## Interface
- `BW`, 16: signed sample width per channel.
- `CH`, 1: channels processed in parallel, packed in the data buses.
- `P_SIZE`, 2: window edge and stride. Legal values are 2 or 4.
- `IF_SIZE`, 8: input map width and height. Must be a multiple of P_SIZE; elaboration fails otherwise.
- `MODE`, 0: 0 = max pooling, 1 = average pooling.

Ports:
- `clk`, in, 1: rising-edge clock.
- `global_rst_n`, in, 1: asynchronous active-low reset.
- `rst`, in, 1: synchronous clear, active-high; takes priority over `i_valid`.
- `i_valid`, in, 1: input beat qualifier (ce); gaps of any length are allowed.
- `i_data`, in, CH*BW: channel c is at bits [c*BW +: BW], two's complement.
- `o_valid`, out, 1: one-cycle pulse per pooled pixel.
- `o_data`, out, CH*BW: pooled pixel, same packing as `i_data`; held until the next `o_valid`.
- `o_end`, out, 1: one-cycle pulse coincident with the last `o_valid` of a frame.

## Operation
- **Position counters.** `col` and `row` each run 0..IF_SIZE-1 and advance only on `i_valid`. `col` wraps to 0 and increments `row`. `row` wraps to 0 after the last pixel, so back-to-back frames need no idle cycle.
- **Horizontal stage (per channel).**
  - When `col%P_SIZE==0`: load `h_acc` with the sample.
  - Otherwise: `h_acc = op(h_acc, sample)`.
  - `op` is signed max in MODE 0 and add in MODE 1.
- **Line buffer.** IF_SIZE/P_SIZE entries per channel, indexed by `col/P_SIZE`. On the last column of a window (`col%P_SIZE==P_SIZE-1`), with `h = op(h_acc, sample)`:
  - If `row%P_SIZE==0`: `lbuf[idx] <= h` (overwrite, so no clear is needed).
  - Otherwise: `v = op(lbuf[idx], h)`.
  - If `row%P_SIZE` is neither 0 nor P_SIZE-1: `lbuf[idx] <= v`.
  - If `row%P_SIZE==P_SIZE-1`: register `o_data <= fin(v)` and pulse `o_valid`.
- **Widths.**
  - MODE 0: accumulators are BW bits; `fin` is the identity.
  - MODE 1: accumulators are BW+2*log2(P_SIZE) bits. `fin` is an arithmetic right shift by 2*log2(P_SIZE), i.e. floor toward −∞, then the low BW bits. The result always fits, so there is no saturation.
- **Frame end.** `o_end` pulses with the `o_valid` produced at `row==IF_SIZE-1`, `col==IF_SIZE-1`.
- **`global_rst_n` low.** Asynchronously clears the counters, `h_acc`, `o_valid`, `o_end` and `o_data`. The line buffer is not reset.
- **`rst` high.** Same clear at the next edge. The input on that cycle is discarded, and the next accepted beat is treated as pixel (0,0). This applies equally mid-frame.

## Timing
- Reset values: `o_valid`=0, `o_end`=0, `o_data`=0.
- Latency: `o_valid`/`o_data` are asserted on the edge after the clock edge that accepts the window's final sample, i.e. registered with 1 cycle latency.
- Output rate: at most one `o_valid` per P_SIZE accepted beats, and only on window-completing rows. Outputs per frame = (IF_SIZE/P_SIZE)².
- `i_valid` low: no state changes and no output pulse. `o_data` holds its value.
- New frame vs. output: the first beat of a new frame on the cycle after the final `o_valid` is accepted normally.
- No `o_ready`: downstream must accept every pulse.

## Test plan
- **Max, baseline.** MODE0, CH=1, P=2, IF=4, input 0..15 raster, contiguous `i_valid` → `o_data` 5, 7, 13, 15. `o_end` with 15. Each pulse is 1 cycle after samples 5, 7, 13, 15.
- **Average, baseline.** MODE1, same input → 2, 4, 10, 12 (floor of 2.5, 4.5, 10.5, 12.5).
- **Negative values.** MODE1, window −1, −2, −3, −4 → −3. MODE0, all −32768 except one −5 → −5.
- **Multi-channel with gaps.** CH=2, P=4, IF=8: ch0 = ramp, ch1 = negated ramp; random 0–3 cycle `i_valid` gaps → 4 outputs per channel. ch0 max = 27, 31, 59, 63; ch1 max = 0, −4, −32, −36. Results are identical to the gap-free run.
- **Reset mid-frame.** Assert `rst` mid-frame (after 6 samples), then stream a full frame → exactly (IF/P)² outputs matching the clean reference, with no stale output. Repeat with `global_rst_n` pulsed asynchronously mid-cycle → outputs are 0 immediately.
- **Back-to-back frames.** Two frames with no idle cycle between them → 2×(IF/P)² `o_valid`, 2 `o_end` pulses, correct values in both frames.
